pulse_voice: RTL and testbench

Pulse-wave voice that sits directly downstream of a channel note sequencer. It consumes the sequencer's phase increment, period top and envelope level. On every audio sample strobe it advances a 32-bit phase accumulator and derives a square-wave polarity. It scales the envelope by a fixed gain using a serial shift-add multiplier, then presents one signed sample per strobe to the mixer over a valid/ready handshake.

---
 rtl/pulse_voice.sv | 80 ++++++++
 tb/tb_pulse_voice.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_voice.sv
// pulse_voice: phase-accumulated pulse wave whose amplitude is envelope x GAIN.
// Produces one signed sample per strobe and hands it to the mixer over valid/ready.
module pulse_voice #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int GAIN = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_sample_stb,
  input  logic [31:0]                    i_phase_delta,
  input  logic [7:0]                     i_top,
  input  logic                           i_top_valid,
  input  logic [8:0]                     i_envelope,
  output logic signed [SAMPLE_WIDTH-1:0] o_sample,
  output logic                           o_sample_valid,
  input  logic                           i_sample_ready,
  output logic                           o_overrun
);
  typedef enum logic [1:0] {IDLE, MUL, SAT, HOLD} state_t;
  localparam logic [15:0] G = 16'(GAIN);
  localparam int MAX = 2 ** (SAMPLE_WIDTH - 1) - 1;
  state_t state, state_nxt;
  logic [31:0] r_phase;
  logic [7:0] r_thresh;
  logic [32:0] sum;
  logic pol, pol_q, rest_q;
  logic [8:0] env;
  logic [15:0] acc;
  logic [3:0] cnt;
  logic [SAMPLE_WIDTH-1:0] mag;
  assign sum = {1'b0, r_phase} + {1'b0, i_phase_delta};
  assign pol = r_phase[31:24] <= r_thresh;
  assign mag = acc > 16'(MAX) ? SAMPLE_WIDTH'(MAX) : SAMPLE_WIDTH'(acc);
  // Duty threshold only reloads on a wrapping strobe so a period is never split
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_phase  <= '0;
      r_thresh <= 8'd127;
    end else if (i_sample_stb) begin
      r_phase <= sum[31:0];
      if (sum[32] && i_top_valid) r_thresh <= i_top >> 1;
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = i_sample_stb ? MUL : IDLE;
      MUL:     state_nxt = cnt == 4'd8 ? SAT : MUL;
      SAT:     state_nxt = HOLD;
      default: state_nxt = i_sample_ready ? IDLE : HOLD;
    endcase
  end
  always_comb o_sample_valid = state == HOLD;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      env       <= '0;
      pol_q     <= 1'b0;
      rest_q    <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      o_sample  <= '0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= i_sample_stb && state != IDLE;
      if (state == IDLE && i_sample_stb) begin
        env    <= i_envelope;
        pol_q  <= pol;
        rest_q <= i_phase_delta == 32'd0;
        acc    <= '0;
        cnt    <= '0;
      end
      if (state == MUL) begin
        acc <= acc + (env[cnt] ? G << cnt : 16'd0);
        cnt <= cnt + 4'd1;
      end
      if (state == SAT) o_sample <= rest_q ? '0 : pol_q ? mag : -mag;
    end
endmodule

// File: tb/tb_pulse_voice.sv
// tb_pulse_voice: scoreboard bench driving two voices (GAIN 64 and 127) from shared stimulus.
module tb_pulse_voice;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stb = 1'b0;
  logic [31:0] delta = '0;
  logic [7:0] top = 8'hFF;
  logic top_valid = 1'b0;
  logic [8:0] envelope = '0;
  logic ready = 1'b1;
  logic signed [15:0] sample64, sample127;
  logic valid64, valid127, ovr64, ovr127;

  typedef struct {logic signed [15:0] a; logic signed [15:0] b; int rise;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_v = 1'b0;
  logic [31:0] m_phase = '0;
  logic [7:0] m_thresh = 8'd127;

  pulse_voice #(.SAMPLE_WIDTH(16), .GAIN(64)) u64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_stb(stb), .i_phase_delta(delta),
    .i_top(top), .i_top_valid(top_valid), .i_envelope(envelope),
    .o_sample(sample64), .o_sample_valid(valid64), .i_sample_ready(ready), .o_overrun(ovr64));
  pulse_voice #(.SAMPLE_WIDTH(16), .GAIN(127)) u127 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_stb(stb), .i_phase_delta(delta),
    .i_top(top), .i_top_valid(top_valid), .i_envelope(envelope),
    .o_sample(sample127), .o_sample_valid(valid127), .i_sample_ready(ready), .o_overrun(ovr127));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [15:0] expv(int g, int e, bit p, bit r);
    int m;
    m = e * g;
    if (m > 32767) m = 32767;
    return r ? 16'sd0 : p ? 16'(m) : 16'(-m);
  endfunction

  // Valid rise timing and accepted samples are checked against the scoreboard head
  always @(negedge clk) begin
    if (valid64 && !prev_v) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid at cycle %0d", cyc);
      end else if (cyc !== sb[0].rise) begin
        errors++;
        $display("FAIL valid_latency got cycle %0d want %0d", cyc, sb[0].rise);
      end
    end
    if (valid64 && ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample got %0d", sample64);
      end else begin
        mon_e = sb.pop_front();
        if (sample64 !== mon_e.a || sample127 !== mon_e.b || valid127 !== 1'b1) begin
          errors++;
          $display("FAIL sample got %0d/%0d (v127=%b) want %0d/%0d",
                   sample64, sample127, valid127, mon_e.a, mon_e.b);
        end
      end
    end
    prev_v = valid64;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_phase = '0;
    m_thresh = 8'd127;
  endtask

  task automatic strobe(input bit accept);
    logic [32:0] s;
    bit p;
    @(posedge clk); #1;
    p = m_phase[31:24] <= m_thresh;
    s = {1'b0, m_phase} + {1'b0, delta};
    if (s[32] && top_valid) m_thresh = top >> 1;
    m_phase = s[31:0];
    if (accept)
      sb.push_back('{expv(64, int'(envelope), p, delta == 0), expv(127, int'(envelope), p, delta == 0), cyc + 11});
    stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    @(negedge clk);
    checks++;
    if (ovr64 !== !accept || ovr127 !== !accept) begin
      errors++;
      $display("FAIL overrun_pulse got %b/%b want %b", ovr64, ovr127, !accept);
    end
    @(negedge clk);
    checks++;
    if (ovr64 !== 1'b0 || ovr127 !== 1'b0) begin
      errors++;
      $display("FAIL overrun_width got %b/%b want 0", ovr64, ovr127);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (sample64 !== 16'sd0 || valid64 !== 1'b0 || ovr64 !== 1'b0 || valid127 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got s=%0d v=%b o=%b want 0 0 0", sample64, valid64, ovr64);
    end
    checks++;
    if (u64.r_phase !== 32'd0 || u64.r_thresh !== 8'd127) begin
      errors++;
      $display("FAIL reset_state got phase=%h thresh=%0d want 0 127", u64.r_phase, u64.r_thresh);
    end
  endtask

  task automatic test_square(input logic [8:0] env);
    envelope = env;
    delta = 32'h4000_0000;
    top = 8'hFF;
    top_valid = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      strobe(1'b1);
      idle(96);
    end
  endtask

  task automatic test_reset_mid();
    envelope = 9'd30;
    delta = 32'h1000_0000;
    ready = 1'b1;
    @(posedge clk); #1;
    stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sample64 !== 16'sd0 || sample127 !== 16'sd0 || valid64 !== 1'b0 || ovr64 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got s=%0d/%0d v=%b o=%b want 0", sample64, sample127, valid64, ovr64);
    end
    checks++;
    if (u64.r_phase !== 32'd0 || u64.r_thresh !== 8'd127) begin
      errors++;
      $display("FAIL async_reset_state got phase=%h thresh=%0d want 0 127", u64.r_phase, u64.r_thresh);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_phase = '0;
    m_thresh = 8'd127;
    idle(20);
    strobe(1'b1);
    idle(15);
  endtask

  task automatic test_backpressure();
    logic [31:0] p0;
    envelope = 9'd30;
    delta = 32'h1000_0000;
    top_valid = 1'b0;
    p0 = m_phase;
    ready = 1'b0;
    strobe(1'b1);
    idle(20);
    strobe(1'b0);
    @(negedge clk);
    checks++;
    if (valid64 !== 1'b1 || sb.size() == 0 || sample64 !== sb[0].a) begin
      errors++;
      $display("FAIL held_sample got s=%0d v=%b want held value", sample64, valid64);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    idle(3);
    checks++;
    if (u64.r_phase !== p0 + 2 * delta) begin
      errors++;
      $display("FAIL phase_after_overrun got %h want %h", u64.r_phase, p0 + 2 * delta);
    end
    idle(10);
  endtask

  task automatic test_duty();
    apply_reset();
    envelope = 9'd30;
    delta = 32'h2000_0000;
    top_valid = 1'b0;
    ready = 1'b1;
    strobe(1'b1);
    idle(15);
    top = 8'h3F;
    top_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      strobe(1'b1);
      idle(15);
    end
    checks++;
    if (u64.r_thresh !== 8'd127) begin
      errors++;
      $display("FAIL thresh_before_wrap got %0d want 127", u64.r_thresh);
    end
    strobe(1'b1);
    idle(15);
    checks++;
    if (u64.r_thresh !== m_thresh || m_thresh !== 8'd31) begin
      errors++;
      $display("FAIL thresh_after_wrap got %0d want 31", u64.r_thresh);
    end
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1);
      idle(15);
    end
    top_valid = 1'b0;
  endtask

  task automatic test_rest();
    logic [31:0] p0;
    p0 = m_phase;
    envelope = 9'd30;
    delta = '0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1);
      idle(15);
    end
    checks++;
    if (u64.r_phase !== p0) begin
      errors++;
      $display("FAIL rest_phase got %h want %h", u64.r_phase, p0);
    end
  endtask

  initial begin
    test_reset();
    test_square(9'd30);
    test_square(9'd511);
    test_reset_mid();
    test_backpressure();
    test_duty();
    test_rest();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
